// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline definitions: memory access encodings and data memory depth
package mem_stage_pkg;

    localparam int DM_WORDS_DEFAULT = 3072;

    typedef enum logic [2:0] {
        MEM_W   = 3'b000,
        MEM_LH  = 3'b001,
        MEM_LHU = 3'b010,
        MEM_LB  = 3'b011,
        MEM_LBU = 3'b100,
        MEM_SH  = 3'b101,
        MEM_SB  = 3'b110
    } mem_op_e;

    // Half-word accesses, loads and stores alike
    function automatic logic is_half_op(input logic [2:0] op);
        return (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    endfunction

endpackage

// File: rtl/mem_ext.sv
// rtl/mem_ext.sv - store lane/byte-enable generation and load extraction/extension; alignment check under MEM_ALIGN_CHECK_EN
module mem_ext
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] write_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (is_half_op(mem_op) && offset[0]) ||
                        ((mem_op == MEM_W) && (offset != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign half_sel = offset[1] ? read_word[31:16] : read_word[15:0];
    assign byte_sel = read_word[{offset, 3'b000} +: 8];

    // Store lanes: the data is replicated so the enabled lanes always see the right bits
    always_comb begin
        byte_en    = 4'b0000;
        write_word = store_data;
        case (mem_op)
            MEM_W: begin
                byte_en    = 4'b1111;
                write_word = store_data;
            end
            MEM_SH: begin
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                write_word = {2{store_data[15:0]}};
            end
            MEM_SB: begin
                byte_en    = 4'b0001 << offset;
                write_word = {4{store_data[7:0]}};
            end
            default: begin
                byte_en    = 4'b0000;
                write_word = store_data;
            end
        endcase
    end

    // Load extraction and sign/zero extension; misaligned accesses return zero
    always_comb begin
        load_data = read_word;
        case (mem_op)
            MEM_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: load_data = {16'h0000, half_sel};
            MEM_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: load_data = {24'h000000, byte_sel};
            default: load_data = read_word;
        endcase
        if (misaligned) begin
            load_data = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data memory and M/W registers; alignment check under MEM_ALIGN_CHECK_EN
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          DM_WORDS = DM_WORDS_DEFAULT,
    parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] result_M_i,
    input  logic [31:0] rt_data_M_i,
    input  logic [31:0] PCn8_M_i,
    input  logic        regWrite_M_i,
    input  logic [4:0]  A3_M_i,
    input  logic [31:0] OP_M_i,
    input  logic        memWrite,
    input  logic [2:0]  memOp,
    input  logic        flush_M,
    output logic [31:0] memory_W_i,
    output logic [31:0] result_W_i,
    output logic [31:0] PCn8_W_i,
    output logic        regWrite_W_i,
    output logic [4:0]  A3_W_i,
    output logic [31:0] OP_W_i,
    output logic        align_err_W
);

    localparam int          AW         = $clog2(DM_WORDS);
    localparam logic [31:0] DM_WORDS_U = 32'(DM_WORDS);

    logic [31:0] dm [DM_WORDS];

    logic [31:0] word_idx;
    logic        in_range;
    logic [31:0] read_word;
    logic [3:0]  byte_en;
    logic [31:0] write_word;
    logic [31:0] load_data;
    logic        misaligned;
    logic        dm_we;
    logic [31:0] merged_word;

    assign word_idx  = (result_M_i - DM_BASE) >> 2;
    assign in_range  = word_idx < DM_WORDS_U;
    assign read_word = in_range ? dm[word_idx[AW-1:0]] : 32'h0000_0000;
    assign dm_we     = memWrite && !flush_M && in_range && !misaligned;

    mem_ext u_mem_ext (
        .mem_op     (memOp),
        .offset     (result_M_i[1:0]),
        .store_data (rt_data_M_i),
        .read_word  (read_word),
        .byte_en    (byte_en),
        .write_word (write_word),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // New contents of the addressed word: enabled lanes from the store, the rest unchanged
    always_comb begin
        merged_word = read_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                merged_word[8*b +: 8] = write_word[8*b +: 8];
            end
        end
    end

    // One register word per entry so reset can clear the whole array asynchronously
    for (genvar w = 0; w < DM_WORDS; w++) begin : g_dm
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dm[w] <= 32'h0000_0000;
            end else if (dm_we && (word_idx == 32'(w))) begin
                dm[w] <= merged_word;
            end
        end
    end

    // M-to-W pipeline register; a flush loads an all-zero bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memory_W_i   <= '0;
            result_W_i   <= '0;
            PCn8_W_i     <= '0;
            regWrite_W_i <= 1'b0;
            A3_W_i       <= '0;
            OP_W_i       <= '0;
            align_err_W  <= 1'b0;
        end else if (flush_M) begin
            memory_W_i   <= '0;
            result_W_i   <= '0;
            PCn8_W_i     <= '0;
            regWrite_W_i <= 1'b0;
            A3_W_i       <= '0;
            OP_W_i       <= '0;
            align_err_W  <= 1'b0;
        end else begin
            memory_W_i   <= load_data;
            result_W_i   <= result_M_i;
            PCn8_W_i     <= PCn8_M_i;
            regWrite_W_i <= regWrite_M_i;
            A3_W_i       <= regWrite_M_i ? A3_M_i : 5'd0;
            OP_W_i       <= OP_M_i;
            align_err_W  <= misaligned;
        end
    end

endmodule
